freq_scan_scheduler: RTL and testbench
======================================

Name: freq_scan_scheduler

Overview:
- Time-shares one square-wave period detector between NUM_CH comparator-conditioned inputs.
- Selects a channel through the detector's input mux and clears the detector while the mux settles.
- Waits for the detector's stability flag, then captures the measured period.
- Emits one result per channel and advances round-robin over enabled channels, as a single sweep or continuously.

Parameters:
- NUM_CH, 4, number of multiplexed input channels (>=2)
- COUNTER_WIDTH, 18, width of the detector period value
- SETTLE_CYCLES, 16, clk cycles that det_clr is held after a mux change (>=1)
- TIMEOUT_CYCLES, 2_000_000, maximum clk cycles in WAIT before a channel is declared unmeasurable
- TO_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- continuous  in  1  1 = repeat sweeps until deasserted
- abort  in  1  one-cycle pulse; terminates any activity
- ch_enable  in  NUM_CH  per-channel enable mask
- det_stable  in  1  detector stability flag
- det_period  in  COUNTER_WIDTH  detector period, valid while det_stable=1
- det_sel  out  $clog2(NUM_CH)  detector input mux select
- det_clr  out  1  synchronous clear to the detector, active-high
- busy  out  1  high in every state except IDLE
- result_valid  out  1  one-cycle result strobe
- result_ch  out  $clog2(NUM_CH)  channel of the result
- result_period  out  COUNTER_WIDTH  captured period; 0 on timeout
- result_timeout  out  1  result is a timeout
- sweep_done  out  1  one-cycle pulse after the last result of a non-continuous sweep

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values: all outputs 0, FSM=IDLE, counters 0.
- FSM states: IDLE, SETTLE, WAIT, REPORT, NEXT.
- IDLE:
  - start=1 with ch_enable!=0 -> SETTLE; det_sel <= lowest enabled channel; settle counter loaded.
  - start with ch_enable==0 is ignored; busy stays 0.
- SETTLE:
  - det_clr=1 for exactly SETTLE_CYCLES cycles, starting the cycle after entry is registered.
  - Then -> WAIT with the timeout counter = 0.
- WAIT:
  - det_clr=0; the timeout counter increments every cycle.
  - det_stable=1 -> capture det_period and det_sel -> REPORT.
  - Otherwise, counter == TIMEOUT_CYCLES-1 -> REPORT with timeout flag set and period 0.
  - det_stable and timeout in the same cycle: stable wins.
- REPORT: result_valid=1 for one cycle; result_* registered and held until the next result.
- NEXT channel selection:
  - Next is the lowest enabled channel index > the current one, using ch_enable sampled in this cycle.
  - If one exists -> SETTLE with det_sel updated.
  - If none and continuous=1 -> wrap to the lowest enabled channel -> SETTLE.
  - If none and continuous=0 -> sweep_done pulse -> IDLE.
  - If ch_enable==0 -> IDLE without sweep_done.
- Latency: start at cycle T gives det_sel valid at T+1 and det_clr high T+1..T+SETTLE_CYCLES. Earliest result_valid is at stable-sample+1.
- Mask changes:
  - ch_enable changes mid-measurement do not affect the current channel.
  - Only the NEXT decision uses the new mask.
- abort:
  - Highest priority, any state: next cycle FSM=IDLE, det_clr=0, busy=0.
  - No result_valid or sweep_done is issued for the aborted channel.
  - det_sel holds its value.
- start while busy is ignored; continuous is sampled only in NEXT.
- Mid-operation reset: outputs return to reset values immediately (asynchronous).

Test Plan:
- NUM_CH=4, SETTLE=4, TIMEOUT=1000, ch_enable=4'b1011, continuous=0, det_stable driven 30 cycles after each clear with det_period=channel*100+50 -> results ch0=50, ch1=150, ch3=350, no ch2; exactly 3 result_valid, then sweep_done, then busy=0.
- Channel 1 never stable, others as above -> ch1 result_timeout=1, period=0, result_valid exactly 1004 cycles (4 settle + 1000 wait) after ch1's det_sel change; ch3 still measured.
- continuous=1, ch_enable=4'b0101 -> sequence ch0, ch2, ch0, ch2...; deassert continuous during a ch0 measurement -> ch2 reported, then sweep_done, then IDLE.
- abort pulsed in SETTLE and separately in WAIT -> busy=0 the next cycle, det_clr=0, no result_valid; a subsequent start begins again at the lowest enabled channel.
- start with ch_enable=0 -> busy stays 0, no det_clr. ch_enable cleared to 0 during WAIT -> current result reported, then IDLE without sweep_done.
- det_stable asserted on the same cycle the timeout expires -> result_timeout=0 and the captured det_period is reported. det_clr width is checked at exactly 4 cycles.

Source files
------------

// File: rtl/freq_scan_scheduler.sv
// rtl/freq_scan_scheduler.sv - round-robin scheduler sharing one period detector across NUM_CH inputs
module freq_scan_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int COUNTER_WIDTH  = 18,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1),
    localparam int SEL_W         = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     continuous,
    input  logic                     abort,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     det_stable,
    input  logic [COUNTER_WIDTH-1:0] det_period,
    output logic [SEL_W-1:0]         det_sel,
    output logic                     det_clr,
    output logic                     busy,
    output logic                     result_valid,
    output logic [SEL_W-1:0]         result_ch,
    output logic [COUNTER_WIDTH-1:0] result_period,
    output logic                     result_timeout,
    output logic                     sweep_done
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT,
        S_REPORT,
        S_NEXT
    } state_t;

    state_t                   r_state;
    logic [SEL_W-1:0]         r_det_sel;
    logic                     r_det_clr;
    logic                     r_busy;
    logic                     r_result_valid;
    logic [SEL_W-1:0]         r_result_ch;
    logic [COUNTER_WIDTH-1:0] r_result_period;
    logic                     r_result_timeout;
    logic                     r_sweep_done;
    logic [SC_W-1:0]          r_settle_cnt;
    logic [TO_WIDTH-1:0]      r_to_cnt;

    logic                     w_any_en;
    logic                     w_next_found;
    logic [SEL_W-1:0]         w_first_ch;
    logic [SEL_W-1:0]         w_next_ch;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_any_en     = |ch_enable;
        w_first_ch   = '0;
        w_next_ch    = '0;
        w_next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i]) begin
                w_first_ch = SEL_W'(i);
            end
            if (ch_enable[i] && (i > int'(r_det_sel))) begin
                w_next_found = 1'b1;
                w_next_ch    = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_det_sel        <= '0;
            r_det_clr        <= 1'b0;
            r_busy           <= 1'b0;
            r_result_valid   <= 1'b0;
            r_result_ch      <= '0;
            r_result_period  <= '0;
            r_result_timeout <= 1'b0;
            r_sweep_done     <= 1'b0;
            r_settle_cnt     <= '0;
            r_to_cnt         <= '0;
        end else begin
            r_result_valid <= 1'b0;
            r_sweep_done   <= 1'b0;
            if (abort) begin
                r_state   <= S_IDLE;
                r_det_clr <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && w_any_en) begin
                            r_det_sel    <= w_first_ch;
                            r_settle_cnt <= SC_W'(SETTLE_CYCLES);
                            r_det_clr    <= 1'b1;
                            r_busy       <= 1'b1;
                            r_state      <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt == SC_W'(1)) begin
                            r_det_clr <= 1'b0;
                            r_to_cnt  <= '0;
                            r_state   <= S_WAIT;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - SC_W'(1);
                        end
                    end
                    S_WAIT: begin
                        // A stable sample on the final timeout cycle still counts as a measurement.
                        if (det_stable) begin
                            r_result_period  <= det_period;
                            r_result_ch      <= r_det_sel;
                            r_result_timeout <= 1'b0;
                            r_result_valid   <= 1'b1;
                            r_state          <= S_REPORT;
                        end else if (r_to_cnt == TO_LAST) begin
                            r_result_period  <= '0;
                            r_result_ch      <= r_det_sel;
                            r_result_timeout <= 1'b1;
                            r_result_valid   <= 1'b1;
                            r_state          <= S_REPORT;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
                        end
                    end
                    S_REPORT: begin
                        r_state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (w_next_found) begin
                            r_det_sel    <= w_next_ch;
                            r_settle_cnt <= SC_W'(SETTLE_CYCLES);
                            r_det_clr    <= 1'b1;
                            r_state      <= S_SETTLE;
                        end else if (!w_any_en) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (continuous) begin
                            r_det_sel    <= w_first_ch;
                            r_settle_cnt <= SC_W'(SETTLE_CYCLES);
                            r_det_clr    <= 1'b1;
                            r_state      <= S_SETTLE;
                        end else begin
                            r_sweep_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                    default: begin
                        r_det_clr <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign det_sel        = r_det_sel;
    assign det_clr        = r_det_clr;
    assign busy           = r_busy;
    assign result_valid   = r_result_valid;
    assign result_ch      = r_result_ch;
    assign result_period  = r_result_period;
    assign result_timeout = r_result_timeout;
    assign sweep_done     = r_sweep_done;

endmodule

// File: tb/tb_freq_scan_scheduler.sv
// tb/tb_freq_scan_scheduler.sv - scoreboard bench with a behavioural detector model
module tb_freq_scan_scheduler;

    localparam int NCH = 4;
    localparam int CW  = 18;
    localparam int SET = 4;
    localparam int TMO = 1000;
    localparam int NEVER = 1_000_000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          abort = 1'b0;
    logic [NCH-1:0] ch_enable = '0;
    logic          det_stable = 1'b0;
    logic [CW-1:0] det_period = '0;
    logic [1:0]    det_sel;
    logic          det_clr;
    logic          busy;
    logic          result_valid;
    logic [1:0]    result_ch;
    logic [CW-1:0] result_period;
    logic          result_timeout;
    logic          sweep_done;

    freq_scan_scheduler #(
        .NUM_CH(NCH), .COUNTER_WIDTH(CW), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
        .ch_enable(ch_enable), .det_stable(det_stable), .det_period(det_period),
        .det_sel(det_sel), .det_clr(det_clr), .busy(busy), .result_valid(result_valid),
        .result_ch(result_ch), .result_period(result_period), .result_timeout(result_timeout),
        .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int period;
        int to;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_results = 0;
    int   n_sweep = 0;
    int   delay_cyc[NCH];
    int   per_val[NCH];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Detector: after a clear ends, reports stable delay_cyc[sel] cycles later.
    int det_cnt = 0;
    bit armed = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || det_clr) begin
            det_stable = 1'b0;
            det_cnt    = 0;
            armed      = det_clr;
            det_period = CW'($urandom);
        end else if (armed && !det_stable) begin
            if (det_cnt == delay_cyc[det_sel]) begin
                det_stable = 1'b1;
                det_period = CW'(per_val[det_sel]);
            end else begin
                det_period = CW'($urandom);
            end
            det_cnt++;
        end
    end

    // Monitor: pops the scoreboard on every result strobe.
    int  cyc = 0;
    int  rise_cyc = 0;
    bit  prev_clr = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (det_clr && !prev_clr) rise_cyc = cyc;
            if (!det_clr && prev_clr && busy) chk("det_clr_width", cyc - rise_cyc, SET);
            prev_clr = det_clr;
            if (result_valid) begin
                n_results++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got ch %0d period %0d, expected none", result_ch, result_period);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_ch", int'(result_ch), e.ch);
                    chk("result_period", int'(result_period), e.period);
                    chk("result_timeout", int'(result_timeout), e.to);
                    if (result_timeout) chk("timeout_latency", cyc - rise_cyc, SET + TMO);
                end
            end
            if (sweep_done) n_sweep++;
        end else begin
            prev_clr = 1'b0;
        end
    end

    // Reference: one result per enabled channel in ascending order; late detectors time out.
    task automatic push_sweep(input logic [NCH-1:0] mask);
        exp_t x;
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                x.ch     = c;
                x.to     = (delay_cyc[c] >= TMO) ? 1 : 0;
                x.period = x.to ? 0 : per_val[c];
                exp_q.push_back(x);
            end
        end
    endtask

    function automatic int lowest(input logic [NCH-1:0] mask);
        for (int c = 0; c < NCH; c++) if (mask[c]) return c;
        return 0;
    endfunction

    task automatic set_plan(input int base_delay);
        for (int c = 0; c < NCH; c++) begin
            delay_cyc[c] = base_delay;
            per_val[c]   = c * 100 + 50;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    task automatic wait_clr(input bit level, input int budget);
        int k = 0;
        while (det_clr != level && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("det_clr_wait", int'(det_clr), int'(level));
    endtask

    task automatic run_sweep(input logic [NCH-1:0] mask);
        int sd0;
        ch_enable = mask;
        sd0 = n_sweep;
        push_sweep(mask);
        pulse_start();
        chk("sel_after_start", int'(det_sel), lowest(mask));
        chk("busy_after_start", int'(busy), 1);
        wait_idle(20000);
        @(negedge clk);
        chk("sweep_done_count", n_sweep - sd0, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, sd0, k;
        bit seen;
        set_plan(30);
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_det_clr", int'(det_clr), 0);
        chk("rst_det_sel", int'(det_sel), 0);
        chk("rst_result_valid", int'(result_valid), 0);
        chk("rst_result_period", int'(result_period), 0);
        chk("rst_sweep_done", int'(sweep_done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(4'b1011);

        delay_cyc[1] = NEVER;
        run_sweep(4'b1011);

        set_plan(30);
        delay_cyc[0] = TMO - 1;
        delay_cyc[2] = TMO;
        run_sweep(4'b0101);

        set_plan(30);
        ch_enable  = 4'b0101;
        continuous = 1'b1;
        for (int i = 0; i < 3; i++) push_sweep(4'b0101);
        r0 = n_results;
        sd0 = n_sweep;
        pulse_start();
        k = 0;
        while (n_results < r0 + 4 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("continuous_results", n_results - r0, 4);
        wait_clr(1'b1, 20);
        chk("continuous_wrap_sel", int'(det_sel), 0);
        continuous = 1'b0;
        wait_idle(2000);
        @(negedge clk);
        chk("continuous_total", n_results - r0, 6);
        chk("continuous_sweep_done", n_sweep - sd0, 1);
        chk("continuous_queue", exp_q.size(), 0);

        set_plan(100);
        ch_enable = 4'b0110;
        r0 = n_results;
        pulse_start();
        @(negedge clk);
        pulse_abort();
        chk("abort_settle_busy", int'(busy), 0);
        chk("abort_settle_clr", int'(det_clr), 0);
        chk("abort_settle_sel", int'(det_sel), 1);
        pulse_start();
        wait_clr(1'b0, 20);
        repeat (10) @(negedge clk);
        pulse_abort();
        chk("abort_wait_busy", int'(busy), 0);
        chk("abort_wait_clr", int'(det_clr), 0);
        repeat (150) @(negedge clk);
        chk("abort_no_result", n_results - r0, 0);
        set_plan(20);
        run_sweep(4'b0110);

        ch_enable = '0;
        pulse_start();
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy || det_clr) seen = 1'b1;
        end
        chk("empty_mask_idle", int'(seen), 0);

        set_plan(30);
        ch_enable = 4'b0011;
        sd0 = n_sweep;
        push_sweep(4'b0001);
        pulse_start();
        wait_clr(1'b0, 20);
        @(negedge clk) ch_enable = '0;
        wait_idle(2000);
        @(negedge clk);
        chk("mask_clear_no_sweep_done", n_sweep - sd0, 0);
        chk("mask_clear_queue", exp_q.size(), 0);

        for (int it = 0; it < 12; it++) begin
            for (int c = 0; c < NCH; c++) begin
                delay_cyc[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 5, TMO + 5))
                                                           : int'($urandom_range(0, 40));
                per_val[c] = int'($urandom_range(1, (1 << CW) - 1));
            end
            run_sweep(NCH'($urandom_range(1, 15)));
        end

        set_plan(30);
        ch_enable = 4'b1111;
        pulse_start();
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_clr", int'(det_clr), 0);
        chk("midreset_sel", int'(det_sel), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
